// File: rtl/seq_pkg.sv
// seq_pkg: shared state type and default widths for the fetch/sequencing unit
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int SEQ_D      = 10;
    localparam int SEQ_LUT_AW = 3;

endpackage

// File: rtl/branch_lut.sv
// branch_lut: 1W1R branch-target register array, cleared by reset, combinational read
module branch_lut
    import seq_pkg::*;
#(
    parameter int D      = SEQ_D,
    parameter int LUT_AW = SEQ_LUT_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [LUT_AW-1:0] waddr,
    input  logic [D-1:0]      wdata,
    input  logic [LUT_AW-1:0] raddr,
    output logic [D-1:0]      rdata
);

    logic [D-1:0] mem [2**LUT_AW];

    // Write port; a read of the entry being written sees the old value until the edge
    always_ff @(posedge clk) begin
        if (reset) mem <= '{default: '0};
        else if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: PC, run handshake, branch LUT and registered ALU flags; SEQ_CYCLE_CNT_EN adds cycle_cnt
module core_sequencer
    import seq_pkg::*;
#(
    parameter int D        = SEQ_D,
    parameter int LUT_AW   = SEQ_LUT_AW,
    parameter int START    = 0,
    parameter int PROG_END = 1023
`ifdef SEQ_CYCLE_CNT_EN
    ,
    parameter int CW       = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              done,
    output logic              busy,
    output logic [D-1:0]      prog_ctr,
    input  logic              stall_i,
    input  logic              halt_i,
    input  logic              branch_i,
    input  logic              rel_i,
    input  logic [LUT_AW-1:0] lut_sel,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [D-1:0]      lut_wdata,
    input  logic              flag_en,
    input  logic              zero_i,
    input  logic              pari_i,
    input  logic              sc_i,
    input  logic              sc_clr,
    input  logic              sc_en,
    output logic              zeroQ,
    output logic              pariQ,
    output logic              scQ
`ifdef SEQ_CYCLE_CNT_EN
    ,
    output logic [CW-1:0]     cycle_cnt
`endif
);

    seq_state_t   state, state_next;
    logic [D-1:0] pc_next, lut_rdata, target;
    logic         zero_next, pari_next, sc_next, at_end;

    branch_lut #(.D(D), .LUT_AW(LUT_AW)) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (lut_sel),
        .rdata (lut_rdata)
    );

    assign at_end = prog_ctr == D'(PROG_END);
    assign target = rel_i ? prog_ctr + lut_rdata : lut_rdata;
    assign done   = state == DONE;
    assign busy   = state == RUN;

    // Next state, next PC and next flags; stall freezes everything, end-of-run beats branches
    always_comb begin
        state_next = state;
        pc_next    = prog_ctr;
        zero_next  = zeroQ;
        pari_next  = pariQ;
        sc_next    = scQ;
        case (state)
            IDLE: if (req) begin
                state_next = RUN;
                pc_next    = D'(START);
                zero_next  = 1'b0;
                pari_next  = 1'b0;
                sc_next    = 1'b0;
            end
            RUN: if (!stall_i) begin
                zero_next = flag_en ? zero_i : zeroQ;
                pari_next = flag_en ? pari_i : pariQ;
                sc_next   = sc_clr ? 1'b0 : (sc_en ? sc_i : scQ);
                if (halt_i || at_end) state_next = DONE;
                else pc_next = branch_i ? target : prog_ctr + D'(1);
            end
            DONE: if (!req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, PC and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prog_ctr <= D'(START);
            zeroQ    <= 1'b0;
            pariQ    <= 1'b0;
            scQ      <= 1'b0;
        end else begin
            state    <= state_next;
            prog_ctr <= pc_next;
            zeroQ    <= zero_next;
            pariQ    <= pari_next;
            scQ      <= sc_next;
        end
    end

`ifdef SEQ_CYCLE_CNT_EN
    // Saturating count of RUN cycles, stalls included; restarted when a run begins
    always_ff @(posedge clk) begin
        if (reset) cycle_cnt <= '0;
        else if (state == IDLE && req) cycle_cnt <= '0;
        else if (state == RUN && cycle_cnt != '1) cycle_cnt <= cycle_cnt + CW'(1);
    end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed and randomized checks of core_sequencer against a behavioural model
module tb_core_sequencer;

    localparam int START    = 3;
    localparam int PROG_END = 40;
    localparam int SAT      = 7;

    logic       clk = 1'b0;
    logic       reset, req, stall_i, halt_i, branch_i, rel_i, lut_we;
    logic       flag_en, zero_i, pari_i, sc_i, sc_clr, sc_en;
    logic [2:0] lut_sel, lut_waddr;
    logic [9:0] lut_wdata, prog_ctr;
    logic       done, busy, zeroQ, pariQ, scQ;
`ifdef SEQ_CYCLE_CNT_EN
    logic [2:0] cycle_cnt;
`endif

    int tests = 0;
    int fails = 0;

    bit m_run, m_fin, m_z, m_p, m_sc;
    int m_pc, m_cnt;
    int m_lut [8];

    core_sequencer #(
        .D(10), .LUT_AW(3), .START(START), .PROG_END(PROG_END)
`ifdef SEQ_CYCLE_CNT_EN
        , .CW(3)
`endif
    ) dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .busy(busy),
        .prog_ctr(prog_ctr), .stall_i(stall_i), .halt_i(halt_i),
        .branch_i(branch_i), .rel_i(rel_i), .lut_sel(lut_sel),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .flag_en(flag_en), .zero_i(zero_i), .pari_i(pari_i), .sc_i(sc_i),
        .sc_clr(sc_clr), .sc_en(sc_en), .zeroQ(zeroQ), .pariQ(pariQ), .scQ(scQ)
`ifdef SEQ_CYCLE_CNT_EN
        , .cycle_cnt(cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic clear_in();
        req = 0; stall_i = 0; halt_i = 0; branch_i = 0; rel_i = 0; lut_we = 0;
        flag_en = 0; zero_i = 0; pari_i = 0; sc_i = 0; sc_clr = 0; sc_en = 0;
        lut_sel = 0; lut_waddr = 0; lut_wdata = 0;
    endtask

    // One clock edge; the model follows the run rules using the inputs present at the edge
    task automatic step();
        int tgt;
        @(posedge clk);
        if (reset) begin
            m_run = 0; m_fin = 0; m_pc = START; m_z = 0; m_p = 0; m_sc = 0; m_cnt = 0;
            foreach (m_lut[k]) m_lut[k] = 0;
        end else begin
            tgt = rel_i ? (m_pc + m_lut[lut_sel]) % 1024 : m_lut[lut_sel];
            if (!m_run && !m_fin) begin
                if (req) begin
                    m_run = 1; m_pc = START; m_z = 0; m_p = 0; m_sc = 0; m_cnt = 0;
                end
            end else if (m_run) begin
                if (m_cnt < SAT) m_cnt++;
                if (!stall_i) begin
                    if (flag_en) begin m_z = zero_i; m_p = pari_i; end
                    if (sc_clr) m_sc = 0; else if (sc_en) m_sc = sc_i;
                    if (halt_i || m_pc == PROG_END) begin m_run = 0; m_fin = 1; end
                    else m_pc = branch_i ? tgt : (m_pc + 1) % 1024;
                end
            end else if (!req) m_fin = 0;
            if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
        end
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1; step(); step(); reset = 0;
    endtask

    task automatic lut_write(input logic [2:0] a, input logic [9:0] d);
        lut_we = 1; lut_waddr = a; lut_wdata = d; step(); lut_we = 0;
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1; req = 1; step(); step();
        tests++;
        if ({done, busy, prog_ctr, zeroQ, pariQ, scQ} !== {1'b0, 1'b0, 10'd3, 3'b000}) begin
            fails++; $display("FAIL reset_state: got %b/%b pc=%0d flags=%b%b%b, want 0/0 pc=3 flags=000",
                              done, busy, prog_ctr, zeroQ, pariQ, scQ);
        end
        reset = 0;
    endtask

    task automatic test_run_to_end();
        int bad = 0;
        do_reset();
        req = 1; step();
        for (int i = START; i <= PROG_END; i++) begin
            if (prog_ctr !== 10'(i) || busy !== 1'b1) bad++;
            if (i < PROG_END) step();
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL run_sequence: %0d cycles off, want PC %0d..%0d", bad, START, PROG_END); end
        step();
        tests++;
        if ({done, busy, prog_ctr} !== {1'b1, 1'b0, 10'(PROG_END)}) begin
            fails++; $display("FAIL run_end: done=%b busy=%b pc=%0d, want 1 0 %0d", done, busy, prog_ctr, PROG_END);
        end
        step(); step();
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL done_held: got %b want 1", done); end
        req = 0; step();
        tests++;
        if ({done, busy} !== 2'b00) begin fails++; $display("FAIL done_release: got %b%b want 00", done, busy); end
    endtask

    task automatic test_branches();
        do_reset();
        lut_write(3'd2, 10'h3FD);
        lut_write(3'd1, 10'd20);
        req = 1; step();
        repeat (4) step();
        tests++;
        if (prog_ctr !== 10'd7) begin fails++; $display("FAIL pre_branch_pc: got %0d want 7", prog_ctr); end
        branch_i = 1; rel_i = 1; lut_sel = 2; step();
        tests++;
        if (prog_ctr !== 10'd4) begin fails++; $display("FAIL rel_branch: got %0d want 4", prog_ctr); end
        rel_i = 0; lut_sel = 1; step();
        tests++;
        if (prog_ctr !== 10'd20) begin fails++; $display("FAIL abs_branch: got %0d want 20", prog_ctr); end
        branch_i = 0; lut_we = 1; lut_waddr = 4; lut_wdata = 10'(PROG_END); step(); lut_we = 0;
        tests++;
        if (prog_ctr !== 10'd21) begin fails++; $display("FAIL increment: got %0d want 21", prog_ctr); end
        branch_i = 1; lut_sel = 4; step();
        tests++;
        if (prog_ctr !== 10'(PROG_END)) begin fails++; $display("FAIL branch_to_end: got %0d want %0d", prog_ctr, PROG_END); end
        step();
        tests++;
        if ({done, prog_ctr} !== {1'b1, 10'(PROG_END)}) begin
            fails++; $display("FAIL end_beats_branch: done=%b pc=%0d want 1 %0d", done, prog_ctr, PROG_END);
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        do_reset();
        lut_write(3'd1, 10'd20);
        req = 1; step();
        repeat (6) step();
        stall_i = 1; branch_i = 1; lut_sel = 1; flag_en = 1; zero_i = 1;
        repeat (3) begin
            step();
            if (prog_ctr !== 10'd9 || zeroQ !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL stall_hold: %0d cycles moved, want pc=9 zeroQ=0", bad); end
        stall_i = 0; step();
        tests++;
        if ({prog_ctr, zeroQ} !== {10'd20, 1'b1}) begin
            fails++; $display("FAIL stall_release: pc=%0d zeroQ=%b want 20 1", prog_ctr, zeroQ);
        end
    endtask

    task automatic test_halt();
        do_reset();
        req = 1; step();
        halt_i = 1; branch_i = 1; step();
        tests++;
        if ({done, busy, prog_ctr} !== {1'b1, 1'b0, 10'd3}) begin
            fails++; $display("FAIL halt: done=%b busy=%b pc=%0d want 1 0 3", done, busy, prog_ctr);
        end
        halt_i = 0; step(); step(); step();
        tests++;
        if ({done, prog_ctr} !== {1'b1, 10'd3}) begin
            fails++; $display("FAIL halt_hold: done=%b pc=%0d want 1 3", done, prog_ctr);
        end
        req = 0; step();
        tests++;
        if ({done, busy, prog_ctr} !== {1'b0, 1'b0, 10'd3}) begin
            fails++; $display("FAIL halt_idle: done=%b busy=%b pc=%0d want 0 0 3", done, busy, prog_ctr);
        end
    endtask

    task automatic test_flags();
        do_reset();
        req = 1; step();
        sc_en = 1; sc_i = 1; step();
        tests++;
        if (scQ !== 1'b1) begin fails++; $display("FAIL sc_load: got %b want 1", scQ); end
        sc_clr = 1; step();
        tests++;
        if (scQ !== 1'b0) begin fails++; $display("FAIL sc_clr_wins: got %b want 0", scQ); end
        sc_clr = 0; sc_en = 0; flag_en = 1; zero_i = 1; pari_i = 1; step();
        flag_en = 0; zero_i = 0; pari_i = 0; step();
        tests++;
        if ({zeroQ, pariQ} !== 2'b11) begin fails++; $display("FAIL flag_latch: got %b%b want 11", zeroQ, pariQ); end
    endtask

    task automatic test_lut_same_cycle();
        do_reset();
        req = 1; step();
        lut_we = 1; lut_waddr = 3; lut_wdata = 15; branch_i = 1; lut_sel = 3; step();
        tests++;
        if (prog_ctr !== 10'd0) begin fails++; $display("FAIL lut_old_read: got %0d want 0", prog_ctr); end
        lut_we = 0; step();
        tests++;
        if (prog_ctr !== 10'd15) begin fails++; $display("FAIL lut_new_read: got %0d want 15", prog_ctr); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        lut_write(3'd1, 10'd20);
        req = 1; step();
        zero_i = 1; flag_en = 1; repeat (3) step(); flag_en = 0;
        reset = 1; req = 0; step();
        tests++;
        if ({done, busy, prog_ctr, zeroQ} !== {1'b0, 1'b0, 10'd3, 1'b0}) begin
            fails++; $display("FAIL reset_mid_run: done=%b busy=%b pc=%0d zeroQ=%b want 0 0 3 0", done, busy, prog_ctr, zeroQ);
        end
        reset = 0; req = 1; step();
        branch_i = 1; lut_sel = 1; step();
        tests++;
        if (prog_ctr !== 10'd0) begin fails++; $display("FAIL lut_cleared: got %0d want 0", prog_ctr); end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset    = $urandom_range(0, 99) == 0;
            req      = $urandom_range(0, 3) != 0;
            stall_i  = $urandom_range(0, 4) == 0;
            halt_i   = $urandom_range(0, 39) == 0;
            branch_i = $urandom_range(0, 5) == 0;
            rel_i    = 1'($urandom);
            lut_sel  = 3'($urandom);
            lut_we   = $urandom_range(0, 7) == 0;
            lut_waddr = 3'($urandom);
            lut_wdata = 10'($urandom);
            flag_en = 1'($urandom); zero_i = 1'($urandom); pari_i = 1'($urandom);
            sc_i = 1'($urandom); sc_clr = $urandom_range(0, 5) == 0; sc_en = 1'($urandom);
            step();
            if ({busy, done, prog_ctr, zeroQ, pariQ, scQ} !== {m_run, m_fin, 10'(m_pc), m_z, m_p, m_sc}) begin
                if (bad < 5) $display("FAIL random_cycle_%0d: got b=%b d=%b pc=%0d f=%b%b%b want b=%b d=%b pc=%0d f=%b%b%b",
                    i, busy, done, prog_ctr, zeroQ, pariQ, scQ, m_run, m_fin, m_pc, m_z, m_p, m_sc);
                bad++;
            end
`ifdef SEQ_CYCLE_CNT_EN
            if (cycle_cnt !== 3'(m_cnt)) begin
                if (bad < 5) $display("FAIL random_cnt_%0d: got %0d want %0d", i, cycle_cnt, m_cnt);
                bad++;
            end
`endif
        end
        tests++;
        if (bad != 0) fails++;
        clear_in();
    endtask

`ifdef SEQ_CYCLE_CNT_EN
    task automatic test_cycle_cnt();
        do_reset();
        req = 1; step();
        tests++;
        if (cycle_cnt !== 3'd0) begin fails++; $display("FAIL cnt_start: got %0d want 0", cycle_cnt); end
        stall_i = 1; step(); step(); stall_i = 0; step();
        tests++;
        if (cycle_cnt !== 3'd3) begin fails++; $display("FAIL cnt_stall: got %0d want 3", cycle_cnt); end
        repeat (7) step();
        tests++;
        if (cycle_cnt !== 3'd7) begin fails++; $display("FAIL cnt_saturate: got %0d want 7", cycle_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_run_to_end();
        test_branches();
        test_stall();
        test_halt();
        test_flags();
        test_lut_same_cycle();
        test_reset_mid_run();
        test_random();
`ifdef SEQ_CYCLE_CNT_EN
        test_cycle_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
